// File: rtl/shift_pkg.sv
// Mode encodings shared by the serial-to-parallel shift register and its bench-facing users.
// Combinational definitions only: no latency, no flow control.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_INVERT = 2'b10,
    MODE_ROTATE = 2'b11
  } mode_e;

  // Bit position written by the next accepted serial bit.
  function automatic int unsigned fill_index(input int unsigned count,
                                             input int unsigned width,
                                             input bit lsb_first);
    return lsb_first ? count : (width - 1 - count);
  endfunction

endpackage

// File: rtl/bit_pointer.sv
// Frame bit counter: 0..WIDTH-1, wraps on the last accepted bit; clear wins over advance.
// Count updates one cycle after advance/clear; no backpressure (caller gates advance).
module bit_pointer #(
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [PTR_W-1:0] count,
  output logic             wrap
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(WIDTH - 1);

  logic [PTR_W-1:0] count_q;
  logic [PTR_W-1:0] count_d;

  // Explicit compare against WIDTH-1 so non-power-of-2 widths never overrun.
  assign wrap  = advance && (count_q == LAST);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (advance) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_register_param.sv
// Serial-to-parallel register with hold/load/invert/rotate modes and a per-frame snapshot.
// One-cycle update latency, all outputs registered; no backpressure, wejscie_valid gates LOAD.
module shift_register_param
  import shift_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  bit LSB_FIRST = 1'b1,
  localparam int PTR_W     = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       tryb,
  input  logic             wejscie,
  input  logic             wejscie_valid,
  output logic [WIDTH-1:0] rejestr,
  output logic [WIDTH-1:0] wyjscie,
  output logic             pelny,
  output logic [PTR_W-1:0] licznik
);

  mode_e            mode;
  logic             load_en;
  logic             clear_ptr;
  logic             wrap;
  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] idx;

  logic [WIDTH-1:0] rejestr_q, rejestr_d;
  logic [WIDTH-1:0] wyjscie_q, wyjscie_d;
  logic             pelny_q, pelny_d;

  assign mode      = mode_e'(tryb);
  assign load_en   = (mode == MODE_LOAD) && wejscie_valid;
  assign clear_ptr = (mode == MODE_INVERT);
  assign idx       = PTR_W'(fill_index(int'(count), WIDTH, LSB_FIRST));

  bit_pointer #(
    .WIDTH(WIDTH)
  ) u_bit_pointer (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear_ptr),
    .advance(load_en),
    .count  (count),
    .wrap   (wrap)
  );

  always_comb begin
    rejestr_d = rejestr_q;
    wyjscie_d = wyjscie_q;
    pelny_d   = 1'b0;
    unique case (mode)
      MODE_LOAD: begin
        if (wejscie_valid) begin
          rejestr_d[idx] = wejscie;
          // Snapshot includes the bit landing on this same edge.
          if (wrap) begin
            wyjscie_d = rejestr_d;
            pelny_d   = 1'b1;
          end
        end
      end
      MODE_INVERT: rejestr_d = ~rejestr_q;
      MODE_ROTATE: rejestr_d = {rejestr_q[WIDTH-2:0], rejestr_q[WIDTH-1]};
      default:     rejestr_d = rejestr_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rejestr_q <= '0;
      wyjscie_q <= '0;
      pelny_q   <= 1'b0;
    end else begin
      rejestr_q <= rejestr_d;
      wyjscie_q <= wyjscie_d;
      pelny_q   <= pelny_d;
    end
  end

  assign rejestr = rejestr_q;
  assign wyjscie = wyjscie_q;
  assign pelny   = pelny_q;
  assign licznik = count;

endmodule

// File: tb/tb_shift_register_param.sv
// Bench for two configurations (8/LSB-first and 5/MSB-first) sharing one stimulus stream.
module tb_shift_register_param;

  localparam logic [1:0] HOLD = 2'd0, LOAD = 2'd1, INV = 2'd2, ROT = 2'd3;

  logic       clock;
  logic       reset;
  logic [1:0] tryb;
  logic       wejscie;
  logic       wejscie_valid;

  logic [7:0] rej8, wy8;
  logic       pel8;
  logic [2:0] cnt8;
  logic [4:0] rej5, wy5;
  logic       pel5;
  logic [2:0] cnt5;

  shift_register_param #(.WIDTH(8), .LSB_FIRST(1'b1)) dut8 (
    .clock(clock), .reset(reset), .tryb(tryb), .wejscie(wejscie),
    .wejscie_valid(wejscie_valid), .rejestr(rej8), .wyjscie(wy8),
    .pelny(pel8), .licznik(cnt8)
  );

  shift_register_param #(.WIDTH(5), .LSB_FIRST(1'b0)) dut5 (
    .clock(clock), .reset(reset), .tryb(tryb), .wejscie(wejscie),
    .wejscie_valid(wejscie_valid), .rejestr(rej5), .wyjscie(wy5),
    .pelny(pel5), .licznik(cnt5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rej;
    logic [31:0] wy;
    int          cnt;
    bit          pel;
  } st_t;

  st_t         m8, m5;
  st_t         q8[$], q5[$];
  logic [31:0] f8[$], f5[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the register as a w-bit number and the frame position as an integer.
  function automatic st_t model(input st_t s, input int w, input bit lsb, input bit rst,
                                input logic [1:0] mode, input bit b, input bit v);
    st_t         n;
    int          pos;
    logic [31:0] mask;
    mask  = (32'd1 << w) - 32'd1;
    n     = s;
    n.pel = 1'b0;
    if (rst) begin
      n.rej = 0; n.wy = 0; n.cnt = 0;
    end else if (mode == LOAD && v) begin
      pos = lsb ? s.cnt : (w - 1 - s.cnt);
      n.rej[pos] = b;
      if (s.cnt == w - 1) begin
        n.cnt = 0; n.wy = n.rej; n.pel = 1'b1;
      end else begin
        n.cnt = s.cnt + 1;
      end
    end else if (mode == INV) begin
      n.rej = ~s.rej & mask;
      n.cnt = 0;
    end else if (mode == ROT) begin
      n.rej = ((s.rej << 1) | (s.rej >> (w - 1))) & mask;
    end
    return n;
  endfunction

  task automatic step(input bit rst, input logic [1:0] mode, input bit b, input bit v);
    @(negedge clock);
    reset = rst; tryb = mode; wejscie = b; wejscie_valid = v;
    m8 = model(m8, 8, 1'b1, rst, mode, b, v);
    m5 = model(m5, 5, 1'b0, rst, mode, b, v);
    q8.push_back(m8);
    q5.push_back(m5);
    if (m8.pel) f8.push_back(m8.wy);
    if (m5.pel) f5.push_back(m5.wy);
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every modelled edge is compared; every pelny pulse must match a predicted frame.
  initial begin
    st_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("rej8", rej8, e.rej); chk("wy8", wy8, e.wy);
        chk("cnt8", cnt8, e.cnt); chk("pel8", pel8, e.pel);
      end
      if (q5.size() > 0) begin
        e = q5.pop_front();
        chk("rej5", rej5, e.rej); chk("wy5", wy5, e.wy);
        chk("cnt5", cnt5, e.cnt); chk("pel5", pel5, e.pel);
      end
      if (pel8) begin
        if (f8.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame8: unexpected pelny, wyjscie 0x%0h at %0t", wy8, $time);
        end else chk("frame8", wy8, f8.pop_front());
      end
      if (pel5) begin
        if (f5.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame5: unexpected pelny, wyjscie 0x%0h at %0t", wy5, $time);
        end else chk("frame5", wy5, f5.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  bit seq31[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
  bit seq34[8] = '{1, 0, 0, 0, 0, 0, 0, 1};
  bit seq36[5] = '{1, 0, 0, 0, 1};

  initial begin
    int r;
    reset = 1'b1; tryb = HOLD; wejscie = 1'b0; wejscie_valid = 1'b0;
    m8 = '{rej: 0, wy: 0, cnt: 0, pel: 0};
    m5 = m8;

    step(1, HOLD, 0, 0); step(1, INV, 1, 1);
    after_edge();
    chk("reset_rej8", rej8, 0); chk("reset_wy8", wy8, 0);
    chk("reset_cnt8", cnt8, 0); chk("reset_pel8", pel8, 0);

    // Full frame
    for (int i = 0; i < 8; i++) step(0, LOAD, seq31[i], 1);
    after_edge();
    chk("frame_rej8", rej8, 32'h4D); chk("frame_wy8", wy8, 32'h4D);
    chk("frame_cnt8", cnt8, 0); chk("frame_pel8", pel8, 1);
    step(0, HOLD, 0, 0);
    after_edge();
    chk("frame_pel8_drop", pel8, 0);

    // Frame with a two-cycle valid gap after the third bit
    step(1, HOLD, 0, 0);
    for (int i = 0; i < 3; i++) step(0, LOAD, seq31[i], 1);
    for (int i = 0; i < 2; i++) begin
      step(0, LOAD, 1, 0);
      after_edge();
      chk("gap_cnt8", cnt8, 3);
    end
    for (int i = 3; i < 8; i++) step(0, LOAD, seq31[i], 1);
    after_edge();
    chk("gap_wy8", wy8, 32'h4D); chk("gap_pel8", pel8, 1);

    // Invert mid-frame, then resume loading
    step(1, HOLD, 0, 0);
    for (int i = 0; i < 3; i++) step(0, LOAD, 1, 1);
    step(0, INV, 0, 1);
    after_edge();
    chk("inv_rej8", rej8, 32'hF8); chk("inv_cnt8", cnt8, 0);
    step(0, LOAD, 0, 1);
    after_edge();
    chk("inv_load_rej8", rej8, 32'hF8); chk("inv_load_cnt8", cnt8, 1);

    // Rotate with MSB and LSB set
    step(1, HOLD, 0, 0);
    for (int i = 0; i < 8; i++) step(0, LOAD, seq34[i], 1);
    step(0, ROT, 0, 1);
    after_edge();
    chk("rot_rej8", rej8, 32'h03); chk("rot_cnt8", cnt8, 0); chk("rot_wy8", wy8, 32'h81);

    // Reset colliding with a LOAD, then a clean frame
    step(1, HOLD, 0, 0);
    for (int i = 0; i < 5; i++) step(0, LOAD, 1, 1);
    step(1, LOAD, 1, 1);
    after_edge();
    chk("rstload_rej8", rej8, 0); chk("rstload_cnt8", cnt8, 0); chk("rstload_pel8", pel8, 0);
    step(0, HOLD, 0, 0);
    after_edge();
    chk("rstload_pel8_after", pel8, 0);
    for (int i = 0; i < 8; i++) step(0, LOAD, seq31[i], 1);
    after_edge();
    chk("rstload_frame_wy8", wy8, 32'h4D);

    // Narrow MSB-first configuration
    step(1, HOLD, 0, 0);
    for (int i = 0; i < 5; i++) step(0, LOAD, seq36[i], 1);
    after_edge();
    chk("w5_rej5", rej5, 32'h11); chk("w5_wy5", wy5, 32'h11);
    chk("w5_cnt5", cnt5, 0); chk("w5_pel5", pel5, 1);
    step(0, HOLD, 0, 0);
    after_edge();
    chk("w5_pel5_drop", pel5, 0);

    // Randomised traffic, LOAD-heavy with occasional reset
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      step($urandom_range(0, 49) == 0,
           (r < 6) ? LOAD : (r == 7) ? INV : (r == 8) ? ROT : HOLD,
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 3; i++) step(0, HOLD, 0, 0);
    after_edge();
    after_edge();
    chk("frames8_left", f8.size(), 0);
    chk("frames5_left", f5.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_register_param.md
SHIFT_REGISTER_PARAM -- requirements
Module: shift_register_param

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH SHALL default to 8 and set the register width; legal values are WIDTH >= 2.
REQ-003 Parameter LSB_FIRST SHALL default to 1; 1 = serial fill from bit 0 upward, 0 = fill from bit WIDTH-1 downward.
REQ-004 Localparam PTR_W SHALL be $clog2(WIDTH).
REQ-005 clock  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 tryb  in  2  mode: 00 HOLD, 01 LOAD, 10 INVERT, 11 ROTATE.
REQ-008 wejscie  in  1  serial data bit.
REQ-009 wejscie_valid  in  1  wejscie is valid this cycle; used only in LOAD.
REQ-010 rejestr  out  WIDTH  live register contents.
REQ-011 wyjscie  out  WIDTH  snapshot of the last completed frame.
REQ-012 pelny  out  1  one-cycle frame-complete pulse.
REQ-013 licznik  out  PTR_W  bits accepted in the current frame (0..WIDTH-1).

Function
REQ-014 All state SHALL update only on the rising edge of clock; outputs SHALL be driven directly from registers.
REQ-015 HOLD SHALL keep rejestr, wyjscie and licznik unchanged, and pelny SHALL be 0.
REQ-016 In LOAD with wejscie_valid=1 the block SHALL write wejscie to rejestr[idx], where idx = licznik if LSB_FIRST=1, else WIDTH-1-licznik; all other bits SHALL hold.
REQ-017 In LOAD with wejscie_valid=1 and licznik<WIDTH-1, licznik SHALL increment by 1.
REQ-018 In LOAD with wejscie_valid=1 and licznik==WIDTH-1, the same edge SHALL:
- wrap licznik to 0;
- load wyjscie with the updated rejestr, including the new bit;
- set pelny to 1.
REQ-019 In LOAD with wejscie_valid=0 the block SHALL behave as HOLD.
REQ-020 pelny SHALL be 1 for exactly the one cycle after a frame-completing edge and 0 otherwise; back-to-back frames SHALL give one pulse per frame.
REQ-021 Wrap SHALL compare explicitly against WIDTH-1 so that non-power-of-2 widths work; licznik SHALL never exceed WIDTH-1.
REQ-022 INVERT SHALL:
- set rejestr to ~rejestr;
- clear licznik to 0, discarding the partial-frame count;
- leave wyjscie unchanged;
- hold pelny at 0.
REQ-023 ROTATE SHALL rotate rejestr one place toward the MSB (old bit WIDTH-1 moves to bit 0); licznik, wyjscie and pelny behave as in HOLD.
REQ-024 A mode change mid-frame SHALL take effect on the next edge with no extra latency; a later return to LOAD SHALL resume at the current licznik.

Reset
REQ-025 When reset=1 at a rising edge, rejestr, wyjscie and licznik SHALL become 0 and pelny SHALL become 0, regardless of tryb or wejscie_valid.
REQ-026 Reset SHALL take priority over a simultaneous frame-completing LOAD; no pelny pulse SHALL follow that edge.
REQ-027 The block SHALL have no initial blocks; reset alone SHALL define the power-up state.

Structure
REQ-028 A shared package shift_pkg SHALL hold the 2-bit mode encodings (HOLD, LOAD, INVERT, ROTATE) as named constants.
REQ-029 The bit-index counter SHALL be a sub-module bit_pointer with ports clock, reset, clear, advance, count and wrap, parametrised by WIDTH.
REQ-030 Data-path muxing by tryb SHALL stay in shift_register_param.

Verification (WIDTH=8, LSB_FIRST=1 unless stated)
REQ-031 Reset, then LOAD with valid on 8 consecutive cycles with bits 1,0,1,1,0,0,1,0 -> after the 8th edge rejestr = wyjscie = 8'b01001101, licznik = 0, and pelny is high for exactly one cycle.
REQ-032 Same bit sequence with wejscie_valid=0 for 2 cycles after the 3rd bit -> licznik stays at 3 during the gap; the final result equals REQ-031 and pelny pulses once.
REQ-033 Load 3 bits 1,1,1, then one INVERT cycle -> rejestr = 8'b11111000 and licznik = 0; the next LOAD bit 0 gives rejestr = 8'b11111000 (bit 0 written) and licznik = 1.
REQ-034 With rejestr = 8'b10000001, apply ROTATE for one cycle -> rejestr = 8'b00000011, and licznik and wyjscie unchanged.
REQ-035 Load 5 bits of 1, then assert reset for one cycle together with LOAD valid -> all outputs 0 and pelny stays 0; a following 8-bit frame completes normally.
REQ-036 With WIDTH=5 and LSB_FIRST=0, load bits 1,0,0,0,1 -> rejestr = wyjscie = 5'b10001, licznik wraps to 0 after the 5th bit, and pelny pulses once.
